// File: rtl/multiwave_generator_pkg.sv
// Shared waveform-mode encoding for the multiwave oscillator and its users.
package multiwave_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SAW = 2'd0;
  localparam mode_t MODE_TRI = 2'd1;
  localparam mode_t MODE_SQR = 2'd2;
  localparam mode_t MODE_OFF = 2'd3;

endpackage

// File: rtl/multiwave_generator_if.sv
// Control/sample bundle between the oscillator (slave) and its controller (master).
interface multiwave_generator_if #(
  parameter int WIDTH  = 16,
  parameter int RATE_W = 8
);
  import multiwave_pkg::*;

  mode_t             mode;
  logic [RATE_W-1:0] rate;
  logic              sync;
  logic [WIDTH-1:0]  pcm;
  logic              pdm_out;
  logic              wrap;
  mode_t             mode_active;

  modport master (
    output mode, rate, sync,
    input  pcm, pdm_out, wrap, mode_active
  );

  modport slave (
    input  mode, rate, sync,
    output pcm, pdm_out, wrap, mode_active
  );

endinterface

// File: rtl/multiwave_generator_pdm_modulator.sv
// First-order PDM: pcm accumulated each clock, carry out is the output bit.
// One clock from pcm to pdm_out; no flow control, consumes a sample every clock.
module pdm_modulator #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pcm,
  output logic             pdm_out
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             pdm_q, pdm_d;
  logic [WIDTH:0]   acc_sum;

  assign acc_sum = {1'b0, acc_q} + {1'b0, pcm};

  always_comb begin
    acc_d = acc_sum[WIDTH-1:0];
    pdm_d = acc_sum[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      pdm_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      pdm_q <= pdm_d;
    end
  end

  assign pdm_out = pdm_q;

endmodule

// File: rtl/multiwave_generator.sv
// Phase-accumulator saw/triangle/square/off oscillator with wrap-aligned mode switching and PDM output.
// Latency: 1 clk to phase/wrap/mode_active, 2 to pcm, 3 to pdm_out; no backpressure, free-running.
module multiwave_generator
  import multiwave_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int RATE_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  multiwave_generator_if.slave bus
);

  logic [WIDTH-1:0] phase_q, phase_d;
  logic             wrap_q, wrap_d;
  mode_t            mode_active_q, mode_active_d;
  logic [WIDTH-1:0] pcm_q, pcm_d;
  logic [WIDTH:0]   phase_sum;
  logic             carry;
  logic [WIDTH-1:0] tri_w;
  logic             pdm_w;

  assign phase_sum = {1'b0, phase_q} + {{(WIDTH + 1 - RATE_W){1'b0}}, bus.rate};
  assign carry     = phase_sum[WIDTH];

  // A new mode is only taken at a waveform boundary (wrap or sync), or
  // immediately when silent, so the output never jumps mid-cycle.
  always_comb begin
    phase_d       = phase_sum[WIDTH-1:0];
    wrap_d        = carry;
    mode_active_d = mode_active_q;
    if (bus.sync) begin
      phase_d = '0;
      wrap_d  = 1'b0;
    end
    if (carry || bus.sync || (mode_active_q == MODE_OFF)) begin
      mode_active_d = bus.mode;
    end
  end

  assign tri_w = {phase_q[WIDTH-2:0], 1'b0};

  always_comb begin
    pcm_d = {1'b1, {(WIDTH-1){1'b0}}};
    case (mode_active_q)
      MODE_SAW: pcm_d = phase_q;
      MODE_TRI: pcm_d = phase_q[WIDTH-1] ? ~tri_w : tri_w;
      MODE_SQR: pcm_d = {WIDTH{phase_q[WIDTH-1]}};
      default:  pcm_d = {1'b1, {(WIDTH-1){1'b0}}};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q       <= '0;
      wrap_q        <= 1'b0;
      mode_active_q <= MODE_OFF;
      pcm_q         <= '0;
    end else begin
      phase_q       <= phase_d;
      wrap_q        <= wrap_d;
      mode_active_q <= mode_active_d;
      pcm_q         <= pcm_d;
    end
  end

  pdm_modulator #(
    .WIDTH (WIDTH)
  ) u_pdm (
    .clk     (clk),
    .reset   (reset),
    .pcm     (pcm_q),
    .pdm_out (pdm_w)
  );

  assign bus.pcm         = pcm_q;
  assign bus.wrap        = wrap_q;
  assign bus.mode_active = mode_active_q;
  assign bus.pdm_out     = pdm_w;

endmodule

// File: doc/multiwave_generator.md
# multiwave_generator

Parametrised phase-accumulator oscillator producing sawtooth, triangle, square or silence on a WIDTH-bit PCM bus, plus a first-order PDM bitstream of that PCM for a one-pin audio output. Next generation of the fixed sawtooth/triangle source: configurable width and step resolution, glitch-free mode switching at waveform wrap, and hard sync. Sits between the board switches/control logic and the pin mux driving `uo_out`/`uio_out`.

## Interface
- `WIDTH`, 16: PCM and phase width, ≥ 4.
- `RATE_W`, 8: width of the phase-step input, ≤ WIDTH.

- `clk` in 1: single clock for all state.
- `reset` in 1: synchronous, active-high; one clock, reset is synchronous and active-high.
- `mode` in 2: requested waveform: 0 saw, 1 triangle, 2 square, 3 off.
- `rate` in RATE_W: phase increment per clock; zero-extended to WIDTH; 0 freezes phase.
- `sync` in 1: hard sync; forces phase to 0 on the next edge.
- `pcm` out WIDTH: unsigned waveform sample, registered.
- `pdm_out` out 1: PDM bit, registered.
- `wrap` out 1: one-cycle pulse when phase overflowed on the last edge.
- `mode_active` out 2: waveform currently generated.

## Operation
- Phase: `phase_next = phase + rate`, computed WIDTH+1 bits wide; carry = natural wrap; low WIDTH bits kept.
- Edge with `sync`=1: phase ← 0, `wrap` ← 0, even if the sum carries; sync beats wrap.
- Otherwise `wrap` ← carry.
- Mode switching: `mode_active` ← `mode` on any edge where carry=1 or `sync`=1, or where `mode_active`=3 (off adopts a new request on the next edge). Otherwise a new `mode` stays pending and is sampled only at the adopting edge; intermediate values are ignored.
- With `rate`=0 and no sync, phase never wraps, so a pending change from saw, triangle or square is not adopted.
- Waveform, from registered phase p and `mode_active`, MSB = p[WIDTH-1], t = {p[WIDTH-2:0],1'b0}:
  - saw: pcm = p.
  - triangle: pcm = t if MSB=0, else ~t.
  - square: pcm = all ones if MSB=1, else 0.
  - off: pcm = midscale, 1 << (WIDTH-1).
- PDM: accumulator acc, WIDTH bits. Each edge: {carry, acc} ← acc + pcm, and `pdm_out` ← carry. Pulse density equals pcm / 2^WIDTH, exactly periodic for constant pcm.
- All arithmetic is unsigned modulo 2^WIDTH; no saturation.

## Timing
- Reset values: phase 0, `pcm` 0, acc 0, `pdm_out` 0, `wrap` 0, `mode_active` 3 (off).
- First edge after reset release: `mode_active` adopts `mode`, because the reset state is off.
- Latency, input to phase/`wrap`/`mode_active`: 1 clock.
- Latency, input to `pcm`: 2 clocks; `pcm` uses the phase and `mode_active` registered on the previous edge.
- Latency, input to `pdm_out`: 3 clocks.
- Mode change lands on `pcm` one cycle after the `wrap` pulse, at phase equal to the post-wrap remainder. There is no discontinuity other than the waveform's own wrap.
- Reset asserted mid-operation clears all state on that edge regardless of `sync`, `rate` or `mode`. Outputs hold reset values while `reset`=1.
- `rate` may change every cycle; it takes effect on the next edge with no pipelining.

## Structure
- Package `multiwave_pkg`: mode constants `MODE_SAW`=0, `MODE_TRI`=1, `MODE_SQR`=2, `MODE_OFF`=3, and a 2-bit `mode_t` typedef.
- Sub-module `pdm_modulator`, parametrised by `WIDTH`: ports `clk`, `reset`, `pcm`, `pdm_out`, holding the acc register. Reusable by other audio sources.
- Top level holds the phase register, the mode/wrap logic and the waveform mux/register.

## Test plan
Bench parameters: WIDTH=8, RATE_W=4.
- Reset, mode=0, rate=0: `mode_active`=0 one cycle after release. `pcm` follows phase 0 and stays 0. `pdm_out` stays 0.
- Saw, rate=15: phase 0,15,30,…,240,255, then 14 with `wrap`=1 exactly on that cycle. `pcm` repeats phase one cycle later.
- Triangle, rate=4 (64 is reachable): phase 64 → `pcm` 128; phase 192 → `pcm` 127; phase 128 → `pcm` 255; phase 0 → `pcm` 0.
- Mode 0→2 requested at phase 100, rate=10: `mode_active` stays 0 until the `wrap` pulse (phase 250→4). `pcm`=0 the cycle after (square, MSB=0); no square output before the wrap.
- Off mode (pcm=128): `pdm_out` = 0,1,0,1… Square high (pcm=255): after a 0 on the first sample, `pdm_out` stays 1 except one 0 every 256 cycles.
- sync=1 on the same edge the phase carries: phase=0, `wrap`=0, pending mode adopted. `reset` pulse mid-saw: next cycle `pcm`=0 and `mode_active`=3.
